// File: rtl/stage4_fast_pack_module_pkg.sv
// Shared sizes and helpers for the stage-4 fast message packer.
// Widths mirror the stage-3 fast encoder's message/length buses.
package stage4_fast_pack_module_pkg;

  localparam int FAST_MESSAGE_BITS   = 128;
  localparam int FAST_LENGTH_BITS    = 8;
  localparam int FAST_OUT_BYTES      = 8;
  localparam int FAST_FRAME_CNT_BITS = 16;

  // Lowest message index >= from whose length is nonzero; 3 means none left.
  function automatic logic [1:0] next_nz(
    input logic [1:0] from,
    input logic [2:0] nz
  );
    next_nz = 2'd3;
    for (int i = 2; i >= 0; i--) begin
      if (nz[i] && 2'(i) >= from) next_nz = 2'(i);
    end
  endfunction

endpackage

// File: rtl/stage4_fast_pack_module_fast_byte_window.sv
// Extracts k bytes of a message starting at off and places them at
// byte position fill of an output word; every other byte is zero.
module fast_byte_window
  import stage4_fast_pack_module_pkg::*;
#(
  parameter int OUT_BYTES = 8,
  parameter int OW        = 5,
  parameter int KW        = 5,
  parameter int FW        = 4
) (
  input  logic [FAST_MESSAGE_BITS-1:0] message,
  input  logic [OW-1:0]                off,
  input  logic [KW-1:0]                k,
  input  logic [FW-1:0]                fill,
  output logic [OUT_BYTES*8-1:0]       slice
);

  localparam int NB  = FAST_MESSAGE_BITS / 8;
  localparam int NBW = $clog2(NB);

  logic [7:0] mb [NB];

  always_comb begin
    for (int i = 0; i < NB; i++) begin
      mb[i] = message[FAST_MESSAGE_BITS-1-8*i -: 8];
    end
  end

  always_comb begin
    int src;
    src   = 0;
    slice = '0;
    for (int j = 0; j < OUT_BYTES; j++) begin
      src = int'(off) + j - int'(fill);
      if (j >= int'(fill) && j < int'(fill) + int'(k) &&
          src >= 0 && src < NB) begin
        slice[(OUT_BYTES-1-j)*8 +: 8] = mb[NBW'(src)];
      end
    end
  end

endmodule

// File: rtl/stage4_fast_pack_module.sv
// Packs the valid bytes of three fast messages into a dense stream of
// fixed-width words with a valid/ready output handshake.
module stage4_fast_pack_module
  import stage4_fast_pack_module_pkg::*;
#(
  parameter int MSG_BYTES = FAST_MESSAGE_BITS / 8,
  parameter int OUT_BYTES = FAST_OUT_BYTES,
  parameter int CNT_BITS  = FAST_FRAME_CNT_BITS
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [FAST_MESSAGE_BITS-1:0] message_fast_1,
  input  logic [FAST_MESSAGE_BITS-1:0] message_fast_2,
  input  logic [FAST_MESSAGE_BITS-1:0] message_fast_3,
  input  logic [FAST_LENGTH_BITS-1:0]  message_fast_length_1,
  input  logic [FAST_LENGTH_BITS-1:0]  message_fast_length_2,
  input  logic [FAST_LENGTH_BITS-1:0]  message_fast_length_3,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [OUT_BYTES*8-1:0]       out_data,
  output logic [3:0]                   out_bytes,
  output logic                         out_last,
  output logic                         len_err,
  output logic [CNT_BITS-1:0]          frame_cnt
);

  localparam int OW = $clog2(MSG_BYTES + 1);
  localparam int FW = $clog2(OUT_BYTES + 1);
  localparam int KW = (OW > FW) ? OW : FW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e state, state_d;

  logic [FAST_MESSAGE_BITS-1:0] msg_q [3];
  logic [OW-1:0]                len_q [3];
  logic [2:0]                   nz_q;
  logic [1:0]                   idx;
  logic [OW-1:0]                off;
  logic [FW-1:0]                fill;
  logic [OUT_BYTES*8-1:0]       word;
  logic [OUT_BYTES*8-1:0]       slice;
  logic                         last_q;
  logic                         err_q;
  logic [CNT_BITS-1:0]          cnt;

  function automatic logic [OW-1:0] clamp_len(
    input logic [FAST_LENGTH_BITS-1:0] l
  );
    if (int'(l) > MSG_BYTES) return OW'(MSG_BYTES);
    return OW'(l);
  endfunction

  logic [OW-1:0] in_len [3];
  logic [2:0]    in_nz;
  logic [2:0]    in_over;

  always_comb begin
    in_len[0]  = clamp_len(message_fast_length_1);
    in_len[1]  = clamp_len(message_fast_length_2);
    in_len[2]  = clamp_len(message_fast_length_3);
    in_over[0] = int'(message_fast_length_1) > MSG_BYTES;
    in_over[1] = int'(message_fast_length_2) > MSG_BYTES;
    in_over[2] = int'(message_fast_length_3) > MSG_BYTES;
    for (int i = 0; i < 3; i++) in_nz[i] = in_len[i] != '0;
  end

  logic [FAST_MESSAGE_BITS-1:0] cur_msg;
  logic [OW-1:0]                cur_len;
  logic [OW-1:0]                new_off;
  logic [KW-1:0]                rem;
  logic [KW-1:0]                space;
  logic [KW-1:0]                k;
  logic [KW-1:0]                new_fill;
  logic [1:0]                   nidx;
  logic                         msg_end;
  logic                         done;
  logic                         accept;

  always_comb begin
    cur_msg = '0;
    cur_len = '0;
    case (idx)
      2'd0: begin cur_msg = msg_q[0]; cur_len = len_q[0]; end
      2'd1: begin cur_msg = msg_q[1]; cur_len = len_q[1]; end
      2'd2: begin cur_msg = msg_q[2]; cur_len = len_q[2]; end
      default: ;
    endcase
    rem      = KW'(cur_len) - KW'(off);
    space    = KW'(OUT_BYTES) - KW'(fill);
    k        = (rem < space) ? rem : space;
    new_off  = off + OW'(k);
    new_fill = KW'(fill) + k;
    msg_end  = new_off == cur_len;
    nidx     = next_nz(idx + 2'd1, nz_q);
    done     = msg_end && nidx == 2'd3;
  end

  fast_byte_window #(
    .OUT_BYTES(OUT_BYTES),
    .OW       (OW),
    .KW       (KW),
    .FW       (FW)
  ) u_window (
    .message(cur_msg),
    .off    (off),
    .k      (k),
    .fill   (fill),
    .slice  (slice)
  );

  always_comb begin
    state_d = state;
    accept  = 1'b0;
    unique case (state)
      IDLE: begin
        accept = in_valid;
        if (in_valid && in_nz != 3'b000) state_d = FILL;
      end
      FILL: if (new_fill == KW'(OUT_BYTES) || done) state_d = HOLD;
      HOLD: if (out_ready) state_d = last_q ? IDLE : FILL;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        msg_q[i] <= '0;
        len_q[i] <= '0;
      end
      nz_q   <= '0;
      idx    <= '0;
      off    <= '0;
      fill   <= '0;
      word   <= '0;
      last_q <= 1'b0;
      err_q  <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          msg_q[0] <= message_fast_1;
          msg_q[1] <= message_fast_2;
          msg_q[2] <= message_fast_3;
          for (int i = 0; i < 3; i++) len_q[i] <= in_len[i];
          nz_q   <= in_nz;
          err_q  <= err_q | (|in_over);
          idx    <= next_nz(2'd0, in_nz);
          off    <= '0;
          fill   <= '0;
          word   <= '0;
          last_q <= 1'b0;
        end
        FILL: begin
          word   <= word | slice;
          fill   <= FW'(new_fill);
          last_q <= done;
          if (msg_end) begin
            idx <= nidx;
            off <= '0;
          end else begin
            off <= new_off;
          end
        end
        HOLD: if (out_ready) begin
          word <= '0;
          fill <= '0;
          if (last_q) cnt <= cnt + CNT_BITS'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = state == IDLE;
  assign out_valid = state == HOLD;
  assign out_data  = out_valid ? word : '0;
  assign out_bytes = out_valid ? 4'(fill) : 4'd0;
  assign out_last  = out_valid & last_q;
  assign len_err   = err_q;
  assign frame_cnt = cnt;

endmodule

// File: tb/tb_stage4_fast_pack_module.sv
// Table-driven bench with a byte-stream reference model and a word
// scoreboard for stage4_fast_pack_module.
module tb_stage4_fast_pack_module;
  import stage4_fast_pack_module_pkg::*;

  localparam int MB = FAST_MESSAGE_BITS / 8;
  localparam int OB = 8;
  localparam int CB = 3;

  typedef struct {
    int l1;
    int l2;
    int l3;
    bit stall;
    int words;
    int last_bytes;
  } vec_t;

  typedef struct {
    logic [OB*8-1:0] data;
    logic [3:0]      bytes;
    logic            last;
  } exp_t;

  logic                         clk;
  logic                         rst_n;
  logic                         in_valid;
  logic                         in_ready;
  logic [FAST_MESSAGE_BITS-1:0] m1, m2, m3;
  logic [FAST_LENGTH_BITS-1:0]  l1, l2, l3;
  logic                         out_valid;
  logic                         out_ready;
  logic [OB*8-1:0]              out_data;
  logic [3:0]                   out_bytes;
  logic                         out_last;
  logic                         len_err;
  logic [CB-1:0]                frame_cnt;

  stage4_fast_pack_module #(
    .OUT_BYTES(OB),
    .CNT_BITS (CB)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .in_valid             (in_valid),
    .in_ready             (in_ready),
    .message_fast_1       (m1),
    .message_fast_2       (m2),
    .message_fast_3       (m3),
    .message_fast_length_1(l1),
    .message_fast_length_2(l2),
    .message_fast_length_3(l3),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .out_data             (out_data),
    .out_bytes            (out_bytes),
    .out_last             (out_last),
    .len_err              (len_err),
    .frame_cnt            (frame_cnt)
  );

  exp_t          sb[$];
  int            checks = 0;
  int            errors = 0;
  logic [CB-1:0] exp_cnt = '0;
  logic          exp_err = 1'b0;
  int            cyc = 0;
  bit            stall_mode = 0;
  bit            ready_auto = 1;
  bit            manual_ready = 0;
  bit            mon_en = 0;
  int            words_seen = 0;
  int            last_bytes_seen = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      if (ready_auto) out_ready = stall_mode ? (cyc % 3 == 0) : 1'b1;
      else            out_ready = manual_ready;
    end
  end

  initial begin
    logic            p_valid;
    logic            p_ready;
    logic [OB*8-1:0] p_data;
    logic [3:0]      p_bytes;
    logic            p_last;
    exp_t            e;
    p_valid = 0; p_ready = 0; p_data = '0; p_bytes = '0; p_last = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (p_valid && !p_ready) begin
          chk("stall_valid", 64'(out_valid), 64'd1);
          chk("stall_data", out_data, p_data);
          chk("stall_bytes", 64'(out_bytes), 64'(p_bytes));
          chk("stall_last", 64'(out_last), 64'(p_last));
        end
        if (sb.size() != 0) chk("in_ready_busy", 64'(in_ready), 64'd0);
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got %h expected none", out_data);
          end else begin
            e = sb.pop_front();
            chk("word_data", out_data, e.data);
            chk("word_bytes", 64'(out_bytes), 64'(e.bytes));
            chk("word_last", 64'(out_last), 64'(e.last));
            words_seen++;
            if (out_last) last_bytes_seen = int'(out_bytes);
          end
        end
      end
      p_valid = out_valid; p_ready = out_ready; p_data = out_data;
      p_bytes = out_bytes; p_last = out_last;
    end
  end

  function automatic int clampi(input int l);
    return (l > MB) ? MB : l;
  endfunction

  task automatic push_expected(input int a, input int b, input int c);
    logic [7:0]      bs[$];
    logic [OB*8-1:0] d;
    exp_t            e;
    int              n;
    int              p;
    for (int i = 0; i < clampi(a); i++) bs.push_back(m1[FAST_MESSAGE_BITS-1-8*i -: 8]);
    for (int i = 0; i < clampi(b); i++) bs.push_back(m2[FAST_MESSAGE_BITS-1-8*i -: 8]);
    for (int i = 0; i < clampi(c); i++) bs.push_back(m3[FAST_MESSAGE_BITS-1-8*i -: 8]);
    p = 0;
    while (p < bs.size()) begin
      d = '0;
      n = 0;
      while (n < OB && p < bs.size()) begin
        d[OB*8-1-8*n -: 8] = bs[p];
        n++;
        p++;
      end
      e.data  = d;
      e.bytes = 4'(n);
      e.last  = (p == bs.size());
      sb.push_back(e);
    end
  endtask

  task automatic load_inputs(input int a, input int b, input int c);
    m1 = {$urandom(), $urandom(), $urandom(), $urandom()};
    m2 = {$urandom(), $urandom(), $urandom(), $urandom()};
    m3 = {$urandom(), $urandom(), $urandom(), $urandom()};
    l1 = 8'(a);
    l2 = 8'(b);
    l3 = 8'(c);
  endtask

  task automatic run_frame(input vec_t v);
    int  ws0;
    bit  got;
    bit  any;
    stall_mode = v.stall;
    ws0 = words_seen;
    any = (v.l1 + v.l2 + v.l3) != 0;
    @(negedge clk);
    load_inputs(v.l1, v.l2, v.l3);
    in_valid = 1'b1;
    got = 0;
    for (int t = 0; t < 50 && !got; t++) begin
      if (in_ready) got = 1;
      else @(negedge clk);
    end
    chk("accept_ready", 64'(got), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    push_expected(v.l1, v.l2, v.l3);
    if (any) exp_cnt = exp_cnt + 1'b1;
    if (v.l1 > MB || v.l2 > MB || v.l3 > MB) exp_err = 1'b1;
    if (clampi(v.l1) >= OB) begin
      @(posedge clk);
      #1;
      chk("first_latency", 64'(out_valid), 64'd1);
    end
    got = 0;
    for (int t = 0; t < 300 && !got; t++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0 && in_ready) got = 1;
    end
    chk("frame_done", 64'(got), 64'd1);
    chk("word_count", 64'(words_seen - ws0), 64'(v.words));
    if (v.words > 0) chk("last_bytes", 64'(last_bytes_seen), 64'(v.last_bytes));
    chk("out_valid_idle", 64'(out_valid), 64'd0);
    chk("frame_cnt", 64'(frame_cnt), 64'(exp_cnt));
    chk("len_err", 64'(len_err), 64'(exp_err));
  endtask

  task automatic wait_valid(input string name);
    bit got;
    got = 0;
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge clk);
      if (out_valid) got = 1;
    end
    chk(name, 64'(got), 64'd1);
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{10, 10, 10, 0, 4, 6};
    vecs[1] = '{13, 13, 13, 0, 5, 7};
    vecs[2] = '{10, 11, 12, 1, 5, 1};
    vecs[3] = '{0, 12, 0, 0, 2, 4};
    vecs[4] = '{0, 0, 0, 0, 0, 0};
    vecs[5] = '{255, 0, 0, 0, 2, 8};
    vecs[6] = '{5, 3, 0, 1, 1, 8};
    vecs[7] = '{1, 1, 1, 0, 1, 3};
    vecs[8] = '{16, 16, 16, 1, 6, 8};
    vecs[9] = '{8, 0, 0, 0, 1, 8};

    rst_n = 1'b0;
    in_valid = 1'b0;
    load_inputs(0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_bytes", 64'(out_bytes), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_len_err", 64'(len_err), 64'd0);
    chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1;

    for (int i = 0; i < 10; i++) run_frame(vecs[i]);

    // Abort a frame with reset while its second word is held.
    mon_en = 0;
    ready_auto = 0;
    manual_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    load_inputs(10, 10, 10);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_valid("abort_word1");
    manual_ready = 1;
    @(posedge clk);
    #3;
    manual_ready = 0;
    @(posedge clk);
    wait_valid("abort_word2");
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_out_data", out_data, 64'd0);
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_len_err", 64'(len_err), 64'd0);
    chk("abort_frame_cnt", 64'(frame_cnt), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    exp_cnt = '0;
    exp_err = 1'b0;
    ready_auto = 1;
    stall_mode = 0;
    @(posedge clk);
    #3;
    @(negedge clk);
    chk("post_rst_valid", 64'(out_valid), 64'd0);
    mon_en = 1;
    run_frame(vecs[1]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
